encoder_counter_top: RTL and testbench



---
 rtl/encoder_counter_pkg.sv | 38 +++
 rtl/encoder_counter_channel.sv | 73 +++++++
 rtl/encoder_counter_top.sv | 64 ++++++
 tb/tb_encoder_counter_top.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_counter_pkg.sv
// Shared constants, types and helpers for the quadrature encoder counter.
// Contents: channel count, count/output widths, decoder step constants,
// default filter lengths, Gray-to-position and step-decode functions.
package encoder_counter_pkg;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 10;
    localparam int OUT_W  = 8;

    // Signed step values produced by the decoder
    localparam int STEP_FWD  = 1;
    localparam int STEP_REV  = -1;
    localparam int STEP_NONE = 0;

    localparam int DEF_FILTER0 = 4;
    localparam int DEF_FILTER1 = 4;
    localparam int DEF_FILTER2 = 1;
    localparam int DEF_FILTER3 = 1;

    // Encoder code q = {p[1], p[1]^p[0]}; inverting it recovers p mod 4
    function automatic logic [1:0] gray2pos(input logic [1:0] q);
        return {q[1], q[1] ^ q[0]};
    endfunction

    // Counter increment (modulo 2^CNT_W) for a prev -> cur code transition.
    // A position delta of 2 (both bits changed) is ambiguous and ignored.
    function automatic logic [CNT_W-1:0] step_inc(input logic [1:0] prev,
                                                  input logic [1:0] cur);
        logic [1:0] delta;
        delta = gray2pos(cur) - gray2pos(prev);
        case (delta)
            2'd1:    return CNT_W'(STEP_FWD);
            2'd3:    return CNT_W'(STEP_REV);
            default: return CNT_W'(STEP_NONE);
        endcase
    endfunction

endpackage

// File: rtl/encoder_counter_channel.sv
// One encoder channel: 2-flop synchroniser, N-sample noise filter,
// direction decoder and 10-bit wrapping up/down counter.
// Ports: clk, rst (async active-low), q (encoder code, async to clk),
//        value (8-bit count view: [7:0] if QUAD_FULL, else [9:2]).
// Latency from input sampled at edge k to value: edge k+N+2.
module encoder_channel
    import encoder_counter_pkg::*;
#(
    parameter int N         = 1,
    parameter bit QUAD_FULL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       q,
    output logic [OUT_W-1:0] value
);

    logic [1:0]       s1, s2, filt, prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= q;
            s2 <= s1;
        end
    end

    generate
        if (N > 1) begin : g_filt
            localparam int RW = $clog2(N + 1);
            logic [1:0]    cand;
            logic [RW-1:0] run;

            // run counts consecutive samples equal to cand; the N-th one
            // commits cand to filt and run then holds at N-1.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cand <= '0;
                    run  <= '0;
                    filt <= '0;
                end else if (s2 != cand) begin
                    cand <= s2;
                    run  <= RW'(1);
                end else if (run == RW'(N - 1)) begin
                    filt <= cand;
                end else begin
                    run <= run + 1'b1;
                end
            end
        end else begin : g_nofilt
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) filt <= '0;
                else      filt <= s2;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= filt;
            cnt  <= cnt + step_inc(prev, filt);
        end
    end

    assign value = QUAD_FULL ? cnt[OUT_W-1:0] : cnt[CNT_W-1:CNT_W-OUT_W];

endmodule

// File: rtl/encoder_counter_top.sv
// Four-channel quadrature encoder counter with 8-bit tri-state read port.
// Ports: clk, rst (async active-low), q0..q3 (2-bit encoder inputs),
//        oe (read enable), sel (channel select),
//        countout (selected channel view, high-Z when oe=0).
// Build option: define NOISE_FILTER_EN to build the per-channel noise
// filters with lengths FILTER0..FILTER3; otherwise every channel runs
// unfiltered (N=1).
module encoder_counter_top
    import encoder_counter_pkg::*;
#(
    parameter int         FILTER0   = DEF_FILTER0,
    parameter int         FILTER1   = DEF_FILTER1,
    parameter int         FILTER2   = DEF_FILTER2,
    parameter int         FILTER3   = DEF_FILTER3,
    parameter logic [3:0] QUAD_FULL = 4'b0011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       q0,
    input  logic [1:0]       q1,
    input  logic [1:0]       q2,
    input  logic [1:0]       q3,
    input  logic             oe,
    input  logic [1:0]       sel,
    output logic [OUT_W-1:0] countout
);

`ifdef NOISE_FILTER_EN
    localparam int N0 = FILTER0;
    localparam int N1 = FILTER1;
    localparam int N2 = FILTER2;
    localparam int N3 = FILTER3;
`else
    // Filters bypassed; FILTERx still referenced so they remain legal overrides
    localparam int N0 = (FILTER0 > 0) ? 1 : 1;
    localparam int N1 = (FILTER1 > 0) ? 1 : 1;
    localparam int N2 = (FILTER2 > 0) ? 1 : 1;
    localparam int N3 = (FILTER3 > 0) ? 1 : 1;
`endif

    localparam int FLEN [NUM_CH] = '{N0, N1, N2, N3};

    logic [NUM_CH-1:0][1:0]       q_all;
    logic [NUM_CH-1:0][OUT_W-1:0] value;

    assign q_all = {q3, q2, q1, q0};

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            encoder_channel #(
                .N         (FLEN[i]),
                .QUAD_FULL (QUAD_FULL[i])
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .q     (q_all[i]),
                .value (value[i])
            );
        end
    endgenerate

    assign countout = oe ? value[sel] : {OUT_W{1'bz}};

endmodule

// File: tb/tb_encoder_counter_top.sv
// Scoreboard bench for encoder_counter_top: reads push expected bytes into
// a queue, a negedge monitor pops and compares while a read is presented.
// High-Z on countout is observed through pullups (reads 8'hFF).
module tb_encoder_counter_top;

`ifdef NOISE_FILTER_EN
    localparam int N1 = 4;
`else
    localparam int N1 = 1;
`endif
    localparam logic [3:0] QF = 4'b0011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       oe  = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [1:0] q [4];
    wire  [7:0] countout;

    for (genvar b = 0; b < 8; b++) begin : g_pu
        pullup (countout[b]);
    end

    encoder_counter_top dut (
        .clk      (clk),
        .rst      (rst),
        .q0       (q[0]),
        .q1       (q[1]),
        .q2       (q[2]),
        .q3       (q[3]),
        .oe       (oe),
        .sel      (sel),
        .countout (countout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq [$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic rd_stb = 1'b0;

    always @(negedge clk) begin
        if (rd_stb) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got %h required an expected entry", countout);
            end else begin
                cur = sbq.pop_front();
                if (countout !== cur.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", cur.name, countout, cur.exp);
                end
            end
        end
    end

    task automatic rd(input string name, input logic o, input logic [1:0] s,
                      input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        oe  = o;
        sel = s;
        sbq.push_back(e);
        rd_stb = 1'b1;
        @(negedge clk);
        #1 rd_stb = 1'b0;
    endtask

    task automatic step(input int ch, input logic [1:0] v, input int cycles);
        @(negedge clk);
        q[ch] = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] gray(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    function automatic logic [7:0] view(input logic [1:0] ch, input logic [9:0] c);
        return QF[ch] ? c[7:0] : c[9:2];
    endfunction

    logic [1:0] fwd [5];
    logic [1:0] rev [4];
    logic [9:0] mcnt [4];
    logic [1:0] mpos [4];

    initial begin
        for (int i = 0; i < 4; i++) q[i] = 2'b00;
        fwd = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        rev = '{2'b10, 2'b11, 2'b01, 2'b00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rd("reset_hiz", 1'b0, 2'd0, 8'hFF);
        for (int c = 0; c < 4; c++)
            rd($sformatf("reset_ch%0d", c), 1'b1, 2'(c), 8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Forward 5 steps: ch2 shows count/4, ch0 shows full count
        for (int i = 0; i < 5; i++) step(2, fwd[i], 40);
        rd("ch2_fwd5", 1'b1, 2'd2, 8'h01);
        for (int i = 0; i < 5; i++) step(0, fwd[i], 40);
        rd("ch0_fwd5", 1'b1, 2'd0, 8'h05);
        rd("ch0_hiz", 1'b0, 2'd0, 8'hFF);
        step(0, 2'b00, 40);
        rd("ch0_back1", 1'b1, 2'd0, 8'h04);
        step(2, 2'b00, 40);
        rd("ch2_back1", 1'b1, 2'd2, 8'h01);

        // Reset asserted mid-count clears immediately
        @(negedge clk) rst = 1'b0;
        #1;
        rd("midreset_ch0", 1'b1, 2'd0, 8'h00);
        rd("midreset_ch2", 1'b1, 2'd2, 8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reverse steps wrap below zero
        for (int i = 0; i < 3; i++) step(0, rev[i], 40);
        rd("ch0_rev3", 1'b1, 2'd0, 8'hFD);
        for (int i = 0; i < 4; i++) step(3, rev[i], 40);
        rd("ch3_rev4", 1'b1, 2'd3, 8'hFF);

        // Two-sample glitch leaves ch1 unchanged
        @(negedge clk) q[1] = 2'b01;
        @(negedge clk);
        @(negedge clk) q[1] = 2'b00;
        repeat (40) @(posedge clk);
        #1;
        rd("ch1_glitch", 1'b1, 2'd1, 8'h00);

        // Held step: visible exactly N+2 edges after first sample
        @(negedge clk) q[1] = 2'b01;
        @(posedge clk);
        repeat (N1 + 1) @(posedge clk);
        #1;
        rd("ch1_lat_before", 1'b1, 2'd1, 8'h00);
        @(posedge clk);
        #1;
        rd("ch1_lat_after", 1'b1, 2'd1, 8'h01);

        // Double step ignored, next single step counts (ch0 at 1021, code 01)
        step(0, 2'b00, 40);
        rd("ch0_pre_dbl", 1'b1, 2'd0, 8'hFC);
        step(0, 2'b11, 40);
        rd("ch0_double", 1'b1, 2'd0, 8'hFC);
        step(0, 2'b10, 40);
        rd("ch0_after_dbl", 1'b1, 2'd0, 8'hFD);

        // Random walk from the known state of every channel
        mcnt = '{10'd1021, 10'd1, 10'd0, 10'd1020};
        mpos = '{2'd3, 2'd1, 2'd0, 2'd0};
        for (int it = 0; it < 200; it++) begin
            logic       o;
            logic [1:0] s;
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                case ($urandom_range(0, 2))
                    1: begin mpos[c] = mpos[c] + 2'd1; mcnt[c] = mcnt[c] + 10'd1; end
                    2: begin mpos[c] = mpos[c] - 2'd1; mcnt[c] = mcnt[c] - 10'd1; end
                    default: ;
                endcase
                q[c] = gray(mpos[c]);
            end
            repeat (12) @(posedge clk);
            #1;
            o = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            rd($sformatf("walk%0d_ch%0d", it, s), o, s, o ? view(s, mcnt[s]) : 8'hFF);
        end

        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
